weights_dma_scheduler: RTL

- Sequences the weight stream for a layer into the weight rotator.
- Accepts one layer descriptor (DDR base address, kernel height, input channels, iteration count).
- Computes the byte length of one weight packet: one header beat, the config beats, then kernel-height × channel rotator beats.
- Issues one DMA read command per iteration at consecutive addresses, and snoops the rotator's input AXIS to confirm each packet completes with the correct beat count before issuing the next command.

---
 rtl/weights_dma_scheduler_if.sv | 39 +++
 rtl/weights_dma_scheduler.sv | 133 +++++++++++++
 2 files changed

// File: rtl/weights_dma_scheduler_if.sv
// Descriptor, DMA command and rotator-snoop signals of the weight DMA scheduler.
// The scheduler uses the slave modport; the host/DMA/rotator side uses master.
interface weights_dma_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int K_W        = 2,
  parameter int CIN_W      = 10,
  parameter int ITR_W      = 10,
  parameter int BTT_WIDTH  = 23
);
  logic                  s_desc_valid;
  logic                  s_desc_ready;
  logic [ADDR_WIDTH-1:0] s_desc_addr;
  logic [K_W-1:0]        s_desc_k_1;
  logic [CIN_W-1:0]      s_desc_cin_1;
  logic [ITR_W-1:0]      s_desc_itr_1;
  logic                  m_cmd_valid;
  logic                  m_cmd_ready;
  logic [ADDR_WIDTH-1:0] m_cmd_addr;
  logic [BTT_WIDTH-1:0]  m_cmd_btt;
  logic                  mon_tvalid;
  logic                  mon_tready;
  logic                  mon_tlast;

  modport slave (
    input  s_desc_valid, s_desc_addr, s_desc_k_1, s_desc_cin_1, s_desc_itr_1,
    output s_desc_ready,
    output m_cmd_valid, m_cmd_addr, m_cmd_btt,
    input  m_cmd_ready,
    input  mon_tvalid, mon_tready, mon_tlast
  );

  modport master (
    output s_desc_valid, s_desc_addr, s_desc_k_1, s_desc_cin_1, s_desc_itr_1,
    input  s_desc_ready,
    input  m_cmd_valid, m_cmd_addr, m_cmd_btt,
    output m_cmd_ready,
    output mon_tvalid, mon_tready, mon_tlast
  );
endinterface

// File: rtl/weights_dma_scheduler.sv
// Issues one DMA read per weight packet of a layer and checks each packet's
// beat count on the snooped rotator input before issuing the next command.
module weights_dma_scheduler #(
  parameter int CORES              = 4,
  parameter int WORD_WIDTH         = 8,
  parameter int KERNEL_W_MAX       = 3,
  parameter int KERNEL_H_MAX       = 3,
  parameter int IM_CIN_MAX         = 1024,
  parameter int ITR_MAX            = 1024,
  parameter int WEIGHTS_DMA_BITS   = 32,
  parameter int BEATS_CONFIG_3X3_1 = 20,
  parameter int BEATS_CONFIG_1X1_1 = 12,
  parameter int ADDR_WIDTH         = 32,
  parameter int BTT_WIDTH          = 23
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  weights_dma_scheduler_if.slave   bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err_len,
  output logic                     err_order
);
  localparam int K_W            = $clog2(KERNEL_H_MAX);
  localparam int CIN_W          = $clog2(IM_CIN_MAX);
  localparam int ITR_W          = $clog2(ITR_MAX);
  localparam int OUT_BEAT_BYTES = KERNEL_W_MAX * CORES * WORD_WIDTH / 8;
  localparam int IN_BEAT_BYTES  = WEIGHTS_DMA_BITS / 8;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_CMD, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] desc_addr_q, cur_addr_q;
  logic [K_W-1:0]        k_1_q;
  logic [CIN_W-1:0]      cin_1_q;
  logic [ITR_W-1:0]      itr_1_q, itr_cnt_q;
  logic [BTT_WIDTH-1:0]  btt_q, exp_beats_q, beat_cnt_q;
  logic                  err_len_q, err_order_q;

  logic [31:0]           cfg_c, w_beats_c;
  logic [BTT_WIDTH-1:0]  btt_c, exp_beats_c;
  logic                  beat, last_beat;

  assign beat      = bus.mon_tvalid && bus.mon_tready;
  assign last_beat = beat && bus.mon_tlast;

  // Packet = header beat + config beats + k*cin rotator beats; the header is one input word.
  always_comb begin
    cfg_c       = (k_1_q == '0) ? 32'(BEATS_CONFIG_1X1_1) : 32'(BEATS_CONFIG_3X3_1);
    w_beats_c   = 32'd2 + cfg_c + (32'(k_1_q) + 32'd1) * (32'(cin_1_q) + 32'd1);
    btt_c       = BTT_WIDTH'((w_beats_c - 32'd1) * 32'(OUT_BEAT_BYTES) + 32'(IN_BEAT_BYTES));
    exp_beats_c = BTT_WIDTH'((32'(btt_c) * 32'd8 + 32'(WEIGHTS_DMA_BITS - 1))
                             / 32'(WEIGHTS_DMA_BITS));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.s_desc_valid) state_d = S_CALC;
      S_CALC: state_d = S_CMD;
      S_CMD:  if (bus.m_cmd_ready) state_d = S_WAIT;
      S_WAIT: if (last_beat) state_d = (itr_cnt_q == itr_1_q) ? S_DONE : S_CMD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_desc_ready = (state_q == S_IDLE);
    bus.m_cmd_valid  = (state_q == S_CMD);
    bus.m_cmd_addr   = cur_addr_q;
    bus.m_cmd_btt    = btt_q;
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_DONE);
    err_len          = err_len_q;
    err_order        = err_order_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      desc_addr_q <= '0;
      cur_addr_q  <= '0;
      k_1_q       <= '0;
      cin_1_q     <= '0;
      itr_1_q     <= '0;
      itr_cnt_q   <= '0;
      btt_q       <= '0;
      exp_beats_q <= '0;
      beat_cnt_q  <= '0;
      err_len_q   <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.s_desc_valid) begin
          desc_addr_q <= bus.s_desc_addr;
          k_1_q       <= bus.s_desc_k_1;
          cin_1_q     <= bus.s_desc_cin_1;
          itr_1_q     <= bus.s_desc_itr_1;
        end
        S_CALC: begin
          btt_q       <= btt_c;
          exp_beats_q <= exp_beats_c;
          itr_cnt_q   <= '0;
          cur_addr_q  <= desc_addr_q;
          beat_cnt_q  <= '0;
        end
        // A tlast before the command is accepted cannot belong to any packet.
        S_CMD: begin
          if (last_beat)  err_order_q <= 1'b1;
          else if (beat)  beat_cnt_q  <= beat_cnt_q + BTT_WIDTH'(1);
        end
        S_WAIT: begin
          if (last_beat) begin
            if (beat_cnt_q + BTT_WIDTH'(1) != exp_beats_q) err_len_q <= 1'b1;
            if (itr_cnt_q != itr_1_q) begin
              itr_cnt_q  <= itr_cnt_q + ITR_W'(1);
              cur_addr_q <= cur_addr_q + ADDR_WIDTH'(btt_q);
              beat_cnt_q <= '0;
            end
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + BTT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
